// File: rtl/inst_prefetch.sv
// inst_prefetch: instruction prefetch unit with a small FIFO queue.
// Issues one word-aligned instruction read at a time, buffers returned
// words together with their fetch address, and serves them to the core
// in order. A flush redirects fetching and empties the queue; a flush
// that lands while a read is still in flight waits out that read (DROP)
// and throws its data away.
// Optional feature: define IFQ_BYPASS_EN to forward a returning word
// straight to the outputs when the queue is empty.
// Handshake: a pop happens on a cycle with o_valid && i_ready (and no
// flush); a memory read is o_mem_req held high with o_mem_addr stable
// until the cycle i_mem_ack is seen, which also carries i_mem_data.
module inst_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_flush,
    input  logic [31:0] i_flush_pc,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_data,
    output logic        o_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    input  logic        i_ready,
    output logic [1:0]  o_dbg_state
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   fpc_q, fpc_d;
    logic [31:0]   drop_addr_q, drop_addr_d;

    logic [31:0]   inst_mem_q [DEPTH];
    logic [31:0]   pc_mem_q   [DEPTH];

    logic          fetch_done;
    logic          bypass;
    logic          bypass_take;
    logic          push;
    logic          pop;
    logic [CW-1:0] count_after;

    // Queue control: which word lands where and what leaves this cycle
    always_comb begin
        fetch_done = (state_q == ST_REQ) && i_mem_ack && !i_flush;
`ifdef IFQ_BYPASS_EN
        bypass = fetch_done && (count_q == '0);
`else
        bypass = 1'b0;
`endif
        // A bypassed word consumed in its arrival cycle never enters the queue
        bypass_take = bypass && i_ready;
        push        = fetch_done && !bypass_take;
        pop         = (count_q != '0) && i_ready && !i_flush;
        count_after = count_q + CW'(push) - CW'(pop);
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: keep at most one read outstanding and never overfill
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!i_flush && (count_q < DEPTH_C)) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (i_flush) begin
                    state_d = i_mem_ack ? ST_IDLE : ST_DROP;
                end else if (i_mem_ack) begin
                    state_d = (count_after < DEPTH_C) ? ST_REQ : ST_IDLE;
                end
            end
            ST_DROP: begin
                // The stale read completes here; its data is discarded
                if (i_mem_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: fetch pointer, drop address, queue pointers
    always_comb begin
        fpc_d       = fpc_q;
        drop_addr_d = drop_addr_q;
        count_d     = count_after;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        if (fetch_done) begin
            fpc_d = fpc_q + 32'd4;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // Remember the in-flight address so it stays stable through DROP
        if ((state_q == ST_REQ) && i_flush && !i_mem_ack) begin
            drop_addr_d = fpc_q;
        end
        if (i_flush) begin
            fpc_d    = i_flush_pc & 32'hFFFF_FFFC;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end
    end

    // Control and pointer registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            fpc_q       <= RESET_PC;
            drop_addr_q <= RESET_PC;
        end else begin
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            fpc_q       <= fpc_d;
            drop_addr_q <= drop_addr_d;
        end
    end

    // Queue storage; contents are only visible through the gated outputs
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem_q[wr_ptr_q] <= i_mem_data;
            pc_mem_q[wr_ptr_q]   <= fpc_q;
        end
    end

    // Outputs: memory request from state, head entry or bypassed word
    always_comb begin
        o_mem_req   = (state_q == ST_REQ) || (state_q == ST_DROP);
        o_mem_addr  = (state_q == ST_DROP) ? drop_addr_q : fpc_q;
        o_dbg_state = state_q;
        o_valid     = 1'b0;
        o_inst      = 32'h0;
        o_pc        = 32'h0;
        if (count_q != '0) begin
            o_valid = 1'b1;
            o_inst  = inst_mem_q[rd_ptr_q];
            o_pc    = pc_mem_q[rd_ptr_q];
        end else if (bypass) begin
            o_valid = 1'b1;
            o_inst  = i_mem_data;
            o_pc    = fpc_q;
        end
    end

endmodule

// File: tb/tb_inst_prefetch.sv
// Testbench for inst_prefetch: directed scenarios plus a random phase,
// with a reference model of the fetch FSM and an expected-entry queue.
module tb_inst_prefetch;

    localparam int DEPTH = 4;

`ifdef IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic        clk;
    logic        rst;
    logic        i_flush;
    logic [31:0] i_flush_pc;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        i_mem_ack;
    logic [31:0] i_mem_data;
    logic        o_valid;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic        i_ready;
    logic [1:0]  o_dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    inst_prefetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (i_flush),
        .i_flush_pc  (i_flush_pc),
        .o_mem_req   (o_mem_req),
        .o_mem_addr  (o_mem_addr),
        .i_mem_ack   (i_mem_ack),
        .i_mem_data  (i_mem_data),
        .o_valid     (o_valid),
        .o_inst      (o_inst),
        .o_pc        (o_pc),
        .i_ready     (i_ready),
        .o_dbg_state (o_dbg_state)
    );

    // ---------------- scoreboard / model state ----------------
    logic [63:0] exp_q[$];       // {pc, inst} in delivery order
    int          m_state;        // 0 idle, 1 request, 2 drop
    logic [31:0] m_fpc;
    logic [31:0] m_drop;
    int          lat;
    int          lat_cnt;
    bit          ready_r;
    bit          const_data;
    int          n_assert;
    int          n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_state = 0;
        m_fpc   = 32'h0;
        m_drop  = 32'h0;
        lat_cnt = 0;
    endtask

    // Assert reset (asynchronously), check cleared outputs, release
    task automatic do_reset();
        rst        = 1'b0;
        i_flush    = 1'b0;
        i_mem_ack  = 1'b0;
        i_ready    = 1'b0;
        #1;
        chk("rst_mem_req", o_mem_req, 32'h0);
        chk("rst_valid", o_valid, 32'h0);
        chk("rst_inst", o_inst, 32'h0);
        chk("rst_pc", o_pc, 32'h0);
        chk("rst_state", o_dbg_state, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    // ---------------- driver: one clock cycle ----------------
    task automatic step(input logic flush, input logic [31:0] fpc_in);
        logic        ack;
        logic [31:0] data;
        logic [31:0] addr;
        bit          byp;
        bit          exp_v;
        logic [63:0] e;
        int          sz0;
        int          old_state;
        sz0       = exp_q.size();
        old_state = m_state;
        addr      = (m_state == 2) ? m_drop : m_fpc;
        ack       = (m_state != 0) && (lat_cnt >= lat);
        data      = const_data ? 32'h0000_0013 : (addr ^ 32'h5A5A_0000);
        i_ready    = ready_r;
        i_flush    = flush;
        i_flush_pc = fpc_in;
        i_mem_ack  = ack;
        i_mem_data = ack ? data : $urandom;
        #1;
        chk("mem_req", o_mem_req, (m_state != 0));
        if (m_state != 0) chk("mem_addr", o_mem_addr, addr);
        chk("dbg_state", o_dbg_state, m_state);
        byp   = BYP && (m_state == 1) && ack && !flush && (sz0 == 0);
        exp_v = (sz0 != 0) || byp;
        chk("valid", o_valid, exp_v);
        if (!exp_v) begin
            chk("inst_when_empty", o_inst, 32'h0);
            chk("pc_when_empty", o_pc, 32'h0);
        end
        if ((m_state == 1) && ack && !flush) begin
            exp_q.push_back({m_fpc, data});
            m_fpc = m_fpc + 32'd4;
        end
        if (exp_v && ready_r && !flush) begin
            e = exp_q.pop_front();
            chk("pop_pc", o_pc, e[63:32]);
            chk("pop_inst", o_inst, e[31:0]);
        end
        case (m_state)
            0: if (!flush && (sz0 < DEPTH)) m_state = 1;
            1: begin
                if (flush) begin
                    if (!ack) m_drop = m_fpc;
                    m_state = ack ? 0 : 2;
                end else if (ack) begin
                    m_state = (exp_q.size() < DEPTH) ? 1 : 0;
                end
            end
            2: if (ack) m_state = 0;
            default: m_state = 0;
        endcase
        if (flush) begin
            exp_q.delete();
            m_fpc = fpc_in & 32'hFFFF_FFFC;
        end
        if (ack || (old_state == 0)) lat_cnt = 0;
        else lat_cnt++;
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        n_assert   = 0;
        n_fail     = 0;
        rst        = 1'b0;
        i_flush    = 1'b0;
        i_flush_pc = 32'h0;
        i_mem_ack  = 1'b0;
        i_mem_data = 32'h0;
        i_ready    = 1'b0;
        ready_r    = 1'b0;
        const_data = 1'b0;
        lat        = 0;
        model_reset();
        @(posedge clk);
        #1;

        // Streaming: ack every cycle, NOP data, core always ready
        do_reset();
        lat = 0; ready_r = 1'b1; const_data = 1'b1;
        step(1'b0, 32'h0);
        chk("first_req_after_reset", o_mem_req, 32'h1);
        chk("first_addr", o_mem_addr, 32'h0);
        repeat (12) step(1'b0, 32'h0);

        // Back-pressure: queue fills to 4, fetch stops, then resumes at 0x10
        do_reset();
        lat = 0; ready_r = 1'b0; const_data = 1'b0;
        repeat (7) step(1'b0, 32'h0);
        chk("full_mem_req", o_mem_req, 32'h0);
        chk("full_valid", o_valid, 32'h1);
        chk("full_head_pc", o_pc, 32'h0);
        ready_r = 1'b1;
        repeat (2) step(1'b0, 32'h0);
        chk("resume_addr", o_mem_addr, 32'h10);
        repeat (10) step(1'b0, 32'h0);

        // Flush while waiting on a slow read: DROP, discard, redirect
        do_reset();
        lat = 3; ready_r = 1'b1;
        repeat (3) step(1'b0, 32'h0);
        step(1'b1, 32'h0000_0102);
        chk("drop_state", o_dbg_state, 32'h2);
        chk("drop_addr_held", o_mem_addr, 32'h0);
        repeat (2) step(1'b0, 32'h0);
        chk("redirect_addr", o_mem_addr, 32'h100);
        chk("redirect_empty", o_valid, 32'h0);
        repeat (10) step(1'b0, 32'h0);

        // Flush coinciding with ack and pop
        do_reset();
        lat = 0; ready_r = 1'b1;
        repeat (4) step(1'b0, 32'h0);
        step(1'b1, 32'h0000_0200);
        chk("flush_ack_empty", o_valid, 32'h0);
        chk("flush_ack_idle", o_dbg_state, 32'h0);
        step(1'b0, 32'h0);
        chk("flush_ack_target", o_mem_addr, 32'h200);
        repeat (6) step(1'b0, 32'h0);

        // Full then draining with continuous acks: pointer wrap
        do_reset();
        lat = 0; ready_r = 1'b0;
        repeat (6) step(1'b0, 32'h0);
        ready_r = 1'b1;
        repeat (24) step(1'b0, 32'h0);

`ifdef IFQ_BYPASS_EN
        // Bypass: empty queue, ack with ready -> word visible in ack cycle
        do_reset();
        lat = 0; ready_r = 1'b1; const_data = 1'b1;
        step(1'b0, 32'h0);
        i_ready = 1'b1; i_mem_ack = 1'b1; i_mem_data = 32'h0000_0013;
        #1;
        chk("bypass_valid", o_valid, 32'h1);
        chk("bypass_inst", o_inst, 32'h13);
        chk("bypass_pc", o_pc, 32'h0);
        step(1'b0, 32'h0);
        ready_r = 1'b0;
        step(1'b0, 32'h0);
        const_data = 1'b0;
        repeat (6) step(1'b0, 32'h0);
`endif

        // Reset in the middle of an outstanding request
        do_reset();
        lat = 3; ready_r = 1'b1;
        repeat (3) step(1'b0, 32'h0);
        do_reset();
        lat = 0;
        repeat (5) step(1'b0, 32'h0);

        // Random traffic: back-pressure, latency and occasional redirects
        do_reset();
        for (int i = 0; i < 400; i++) begin
            ready_r = ($urandom_range(0, 3) != 0);
            if (lat_cnt == 0) lat = $urandom_range(0, 2);
            if ($urandom_range(0, 15) == 0)
                step(1'b1, $urandom_range(0, 32'hFFFF));
            else
                step(1'b0, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
